clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run/stop and reconfiguration controller for a programmable clock divider.
- Owns the divider's half-period counter. Accepts new divide ratios over a valid/ready handshake and applies them only at half-period boundaries, so `cout` never glitches.
- Starts and stops the divided output cleanly, always leaving `cout` low when idle.
- Sits between a register/bus front end and logic consuming `cout` or `tick`; `tick` is a clock-enable, preferred over using `cout` as a clock.

Parameters:
- WIDTH, 32, width of the half-period counter and the ratio value.
- DEFAULT_MAX, 1, ratio value loaded into `cur_max` at reset.

Ports:
- C  in  1  clock.
- clr_n  in  1  synchronous active-low reset; sampled on rising edge of C.
- run  in  1  level request to run the divider.
- cfg_valid  in  1  new ratio offered.
- cfg_max  in  WIDTH  new ratio; half-period is cfg_max+1 cycles of C.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- cout  out  1  divided square wave, registered.
- tick  out  1  one-cycle pulse, registered, high in the same cycle `cout` changes.
- cur_max  out  WIDTH  ratio currently in effect.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (clr_n=0 at edge), also when reset arrives mid-operation or with an update pending:
  - state=IDLE, counter=0, cout=0, tick=0, cur_max=DEFAULT_MAX, pending flag cleared, cfg_ready=1.
- States: IDLE, RUN, STOPPING.
- Boundary: a cycle with state in {RUN, STOPPING} and counter==cur_max.
  - At boundary: counter<=0, cout<=~cout, tick<=1.
  - Non-boundary cycle in RUN/STOPPING: counter<=counter+1, tick<=0.
  - In IDLE: counter holds 0, tick=0.
- Output timing:
  - The first rise of `cout` occurs cur_max+1 cycles after the state becomes RUN.
  - Full period is 2*(cur_max+1) cycles.
  - cur_max=0 gives cout toggling every cycle (period 2).
- IDLE transitions:
  - run=1 → RUN with counter=0.
  - A handshake in IDLE (cfg_valid & cfg_ready) sets cur_max<=cfg_max directly at that edge.
- RUN transitions:
  - run=0 and cout=0 → IDLE at the next edge; counter<=0, no tick.
  - run=0 and cout=1 → STOPPING; counting continues.
- STOPPING transitions:
  - At a boundary, cout falls, tick=1, then → IDLE with counter=0.
  - If run returns to 1 before that boundary → RUN with no disturbance to counter or cout.
- Handshake:
  - cfg_ready = ~pending.
  - Accept = cfg_valid & cfg_ready.
  - Accept in RUN/STOPPING: pend_max<=cfg_max, pending<=1.
  - At the next boundary: cur_max<=pend_max, pending<=0. The new ratio governs the following half-period.
  - If an accept coincides with a boundary, the value waits for the *next* boundary; the coincident boundary uses the old pending (if any) or cur_max.
  - A pending update still in effect when STOPPING reaches its boundary is applied there.
  - If run=0 drops RUN straight to IDLE with pending=1, the pending value is applied at that edge.
- Width rules:
  - counter and comparison are WIDTH bits, unsigned.
  - counter never exceeds cur_max, because reload only happens at a boundary (counter reset to 0).
- Simultaneous run falling and a boundary in RUN with cout=1: the toggle brings cout to 0, so the next state is IDLE, not STOPPING.
- busy is combinational from state.
- All other outputs are registers.

Decomposition:
- Package clk_div_pkg:
  - state enum ST_IDLE/ST_RUN/ST_STOPPING (2 bits).
  - Default WIDTH constant.
- Sub-module clk_div_counter:
  - Inputs: en, load_zero.
  - Compare against max.
  - Outputs: `boundary` strobe and counter.
- Controller FSM, pending register and cout/tick registers stay in clk_div_ctrl.

Test Plan:
- Reset then idle: hold clr_n=0 2 cycles, release → cout=0, tick=0, cur_max=1, cfg_ready=1, busy=0, and they stay so for 20 cycles with run=0.
- Start/period: IDLE load cfg_max=3, run=1 → cout rises 4 cycles after busy=1; period is 8 cycles; tick pulses every 4 cycles, aligned with each cout edge.
- Live update: running at max=3, offer cfg_max=1 mid half-period → cfg_ready=0 until the next boundary; half-periods then become 2 cycles; no cout pulse shorter than 2 cycles.
- Coincident accept: assert cfg_valid (max=0) in the same cycle as a boundary at max=2 → one more 3-cycle half-period, then toggling every cycle.
- Clean stop: drop run while cout=1 → STOPPING, cout falls at the boundary, busy=0 next cycle. Drop run while cout=0 → busy=0 the next cycle, cout stays 0. Re-raise run in STOPPING → continuous waveform with no phase jump.
- Reset mid-operation: clr_n=0 during RUN with an update pending → next cycle all reset values; the pending ratio is discarded, cur_max=DEFAULT_MAX.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider controller: FSM state encoding and
// default counter width.
package clk_div_pkg;

   localparam int unsigned DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

endpackage

// File: rtl/clk_div_counter.sv
// Half-period counter: counts 0..max while enabled and strobes `boundary`
// in the cycle the count equals max.
module clk_div_counter
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             load_zero,
   input  logic [WIDTH-1:0] max,
   output logic             boundary,
   output logic [WIDTH-1:0] count
);

   assign boundary = en && (count == max);

   // Wrapping only at max keeps count <= max as long as max changes only here.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (load_zero) begin
         count <= '0;
      end else if (en) begin
         if (boundary) begin
            count <= '0;
         end else begin
            count <= count + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and glitch-free reconfiguration controller for a programmable
// clock divider; cout toggles only at half-period boundaries.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned DEFAULT_MAX = 1
) (
   input  logic             C,
   input  logic             clr_n,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_max,
   output logic             cfg_ready,
   output logic             cout,
   output logic             tick,
   output logic [WIDTH-1:0] cur_max,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   state_t           state;
   state_t           state_nxt;
   logic             pending;
   logic [WIDTH-1:0] pend_max;
   logic [WIDTH-1:0] count;
   logic             active;
   logic             boundary;
   logic             toggle;
   logic             to_idle;
   logic             accept;
   logic             apply;

   // Handshake: a ratio transfers on any edge where cfg_valid && cfg_ready.
   // cfg_ready drops while a ratio waits for its boundary; the offered value
   // must stay stable on cfg_max while cfg_valid is high and ready is low.
   assign cfg_ready = ~pending;
   assign accept    = cfg_valid & cfg_ready;

   assign active    = (state == ST_RUN) || (state == ST_STOPPING);
   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

   clk_div_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk       (C),
      .clr_n     (clr_n),
      .en        (active),
      .load_zero (to_idle),
      .max       (cur_max),
      .boundary  (boundary),
      .count     (count)
   );

   always_comb begin
      state_nxt = state;
      toggle    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!run && !cout) begin
               // Already low: stop at once, a boundary here must not raise cout.
               state_nxt = ST_IDLE;
            end else begin
               toggle = boundary;
               if (!run) begin
                  state_nxt = boundary ? ST_IDLE : ST_STOPPING;
               end
            end
         end
         ST_STOPPING: begin
            toggle = boundary;
            if (run) begin
               state_nxt = ST_RUN;
            end else if (boundary) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign to_idle = (state != ST_IDLE) && (state_nxt == ST_IDLE);

   // A waiting ratio lands at a boundary, on the way into IDLE, or (if it was
   // accepted on that very edge) on the first IDLE cycle.
   assign apply = pending && (toggle || to_idle || (state == ST_IDLE));

   always_ff @(posedge C) begin
      if (!clr_n) begin
         state    <= ST_IDLE;
         cout     <= 1'b0;
         tick     <= 1'b0;
         cur_max  <= WIDTH'(DEFAULT_MAX);
         pending  <= 1'b0;
         pend_max <= '0;
      end else begin
         state <= state_nxt;
         tick  <= toggle;
         if (toggle) begin
            cout <= ~cout;
         end

         if (accept && (state == ST_IDLE)) begin
            cur_max <= cfg_max;
         end else if (apply) begin
            cur_max <= pend_max;
         end

         if (accept && (state != ST_IDLE)) begin
            pending  <= 1'b1;
            pend_max <= cfg_max;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: table-driven ratio sweep plus
// hand-written sequences for live update, stop, restart and reset.
module tb_clk_div_ctrl;

   localparam int W = 32;

   logic         C         = 1'b0;
   logic         clr_n     = 1'b0;
   logic         run       = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_max   = '0;
   logic         cfg_ready;
   logic         cout;
   logic         tick;
   logic [W-1:0] cur_max;
   logic         busy;
   logic [1:0]   dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // {expected cout level after the edge, cycles since previous edge}
   logic [16:0] exp_q[$];

   typedef struct {
      int unsigned max;
      int unsigned edges;
      int unsigned half;
   } vec_t;

   vec_t vecs[5];

   clk_div_ctrl #(
      .WIDTH       (W),
      .DEFAULT_MAX (1)
   ) dut (
      .C         (C),
      .clr_n     (clr_n),
      .run       (run),
      .cfg_valid (cfg_valid),
      .cfg_max   (cfg_max),
      .cfg_ready (cfg_ready),
      .cout      (cout),
      .tick      (tick),
      .cur_max   (cur_max),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 C = ~C;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge C);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic load(input int m);
      cfg_valid = 1'b1;
      cfg_max   = W'(m);
      step();
      cfg_valid = 1'b0;
      check("cur_max_load", cur_max, 32'(m));
   endtask

   task automatic start();
      run = 1'b1;
      step();
      check("busy_start", 32'(busy), 32'(1));
   endtask

   task automatic push_edges(input int n, input int half, input logic first_level);
      for (int i = 0; i < n; i++) begin
         logic [31:0] iv;
         logic        lvl;
         iv  = 32'(i);
         lvl = first_level ^ iv[0];
         exp_q.push_back({lvl, 16'(half)});
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic run_sb(input int start_cnt, input int budget);
      int          cnt;
      int          used;
      logic [16:0] e;
      cnt  = start_cnt;
      used = 0;
      while (exp_q.size() > 0 && used < budget) begin
         step();
         cnt++;
         used++;
         if (tick) begin
            e = exp_q.pop_front();
            check("edge_interval", 32'(cnt), {16'd0, e[15:0]});
            check("edge_level", 32'(cout), 32'(e[16]));
            cnt = 0;
         end
      end
      if (exp_q.size() > 0) begin
         check("sb_timeout", 32'(exp_q.size()), 32'(0));
         exp_q.delete();
      end
   endtask

   // ---------------- test ----------------
   initial begin
      vecs[0] = '{3, 4, 4};
      vecs[1] = '{0, 6, 1};
      vecs[2] = '{1, 4, 2};
      vecs[3] = '{5, 2, 6};
      vecs[4] = '{2, 4, 3};

      // Reset then idle
      clr_n = 1'b0;
      step();
      step();
      clr_n = 1'b1;
      check("rst_cout", 32'(cout), 32'(0));
      check("rst_tick", 32'(tick), 32'(0));
      check("rst_cur_max", cur_max, 32'(1));
      check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_state", 32'(dbg_state), 32'(0));
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_hold", {29'd0, cout, tick, busy}, 32'(0));
      end

      // Ratio sweep: load in IDLE, run, check every edge interval, stop at cout=0
      for (int v = 0; v < 5; v++) begin
         load(int'(vecs[v].max));
         start();
         push_edges(int'(vecs[v].edges), int'(vecs[v].half), 1'b1);
         run_sb(0, int'(vecs[v].edges * vecs[v].half) + 10);
         run = 1'b0;
         step();
         check("stop_low_busy", 32'(busy), 32'(0));
         check("stop_low_cout", 32'(cout), 32'(0));
         check("stop_low_tick", 32'(tick), 32'(0));
      end

      // Live update mid half-period: 3 -> 1
      load(3);
      start();
      step();
      step();
      cfg_valid = 1'b1;
      cfg_max   = W'(1);
      step();
      cfg_valid = 1'b0;
      check("live_ready_low", 32'(cfg_ready), 32'(0));
      check("live_no_tick", 32'(tick), 32'(0));
      check("live_old_max", cur_max, 32'(3));
      step();
      check("live_tick", 32'(tick), 32'(1));
      check("live_cout", 32'(cout), 32'(1));
      check("live_ready_back", 32'(cfg_ready), 32'(1));
      check("live_new_max", cur_max, 32'(1));
      push_edges(4, 2, 1'b0);
      run_sb(0, 20);

      // Clean stop from cout=1 through STOPPING
      run = 1'b0;
      step();
      check("stopping_state", 32'(dbg_state), 32'(2));
      check("stopping_cout", 32'(cout), 32'(1));
      step();
      check("stopping_fall", 32'(cout), 32'(0));
      check("stopping_tick", 32'(tick), 32'(1));
      check("stopping_idle", 32'(busy), 32'(0));
      step();
      check("stopped_tick", 32'(tick), 32'(0));

      // Accept coincident with a boundary at max=2, switching to 0
      load(2);
      start();
      step();
      step();
      cfg_valid = 1'b1;
      cfg_max   = W'(0);
      step();
      cfg_valid = 1'b0;
      check("coinc_tick", 32'(tick), 32'(1));
      check("coinc_ready", 32'(cfg_ready), 32'(0));
      check("coinc_max", cur_max, 32'(2));
      push_edges(1, 3, 1'b0);
      push_edges(3, 1, 1'b1);
      run_sb(0, 20);
      check("coinc_final_max", cur_max, 32'(0));

      // run falls on a boundary with cout=1: straight to IDLE
      run = 1'b0;
      step();
      check("simul_cout", 32'(cout), 32'(0));
      check("simul_tick", 32'(tick), 32'(1));
      check("simul_busy", 32'(busy), 32'(0));
      step();
      check("simul_quiet", {30'd0, tick, cout}, 32'(0));

      // Re-raise run in STOPPING: no phase jump
      load(3);
      start();
      push_edges(1, 4, 1'b1);
      run_sb(0, 20);
      run = 1'b0;
      step();
      check("rerun_stopping", 32'(dbg_state), 32'(2));
      run = 1'b1;
      step();
      check("rerun_run", 32'(dbg_state), 32'(1));
      check("rerun_cout", 32'(cout), 32'(1));
      push_edges(3, 4, 1'b0);
      run_sb(2, 30);
      run = 1'b0;
      step();
      check("rerun_idle", {30'd0, busy, cout}, 32'(0));

      // Reset mid-operation with a pending ratio
      load(3);
      start();
      step();
      cfg_valid = 1'b1;
      cfg_max   = W'(7);
      step();
      cfg_valid = 1'b0;
      check("midrst_pending", 32'(cfg_ready), 32'(0));
      clr_n = 1'b0;
      run   = 1'b0;
      step();
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_cout", 32'(cout), 32'(0));
      check("midrst_tick", 32'(tick), 32'(0));
      check("midrst_max", cur_max, 32'(1));
      check("midrst_ready", 32'(cfg_ready), 32'(1));
      check("midrst_state", 32'(dbg_state), 32'(0));
      clr_n = 1'b1;
      step();
      start();
      push_edges(2, 2, 1'b1);
      run_sb(0, 20);
      run = 1'b0;
      step();
      check("midrst_final_idle", 32'(busy), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
